// File: rtl/gbuff_out_writer_pkg.sv
// gbuff_out_writer_pkg: shared widths and FSM encoding for the output writer
package gbuff_out_writer_pkg;
  localparam int WORD_SIZE = 32;
  localparam int GBUFF_ADDR_SIZE = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/gbuff_out_writer.sv
// gbuff_out_writer: writes result beats row-major into the output global buffer
module gbuff_out_writer
  import gbuff_out_writer_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE,
  parameter int ADDR_W = GBUFF_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        m,
  input  logic [3:0]        n,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);
  localparam int LANES = DATA_W / 8;
  state_e state_q, state_d;
  logic [3:0] m_q, m_d, n_q, n_d, row_q, row_d;
  logic [1:0] wpr_q, wpr_d, blk_q, blk_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, masked;
  logic wr_en_q, wr_en_d, last_q, last_d;
  logic ready, hs, eol, fin;
  assign ready = state_q == RUN && !last_q && !rst;
  assign hs = res_valid && ready;
  assign eol = blk_q == wpr_q - 2'd1;
  assign fin = eol && row_q == m_q - 4'd1;
  assign res_ready = ready;
  assign wr_en = wr_en_q && !rst;
  assign wr_addr = rst ? '0 : wr_addr_q;
  assign wr_data = rst ? '0 : wr_data_q;
  assign done = state_q == DONE && !rst;
  // zero the lanes whose column lies beyond n
  always_comb begin
    masked = res_data;
    for (int j = 0; j < LANES; j++)
      if (LANES * int'(blk_q) + j >= int'(n_q)) masked[8*j+:8] = 8'h00;
  end
  // next state: job capture, beat counters and registered write port
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    n_d = n_q;
    wpr_d = wpr_q;
    row_d = hs && eol ? row_q + 4'd1 : row_q;
    blk_d = hs ? (eol ? 2'd0 : blk_q + 2'd1) : blk_q;
    addr_d = hs ? addr_q + ADDR_W'(1) : addr_q;
    last_d = last_q || (hs && fin);
    wr_en_d = hs;
    wr_addr_d = hs ? addr_q : wr_addr_q;
    wr_data_d = hs ? masked : wr_data_q;
    if (state_q == RUN && last_q) state_d = DONE;
    if (state_q != RUN && start) begin
      m_d = m;
      n_d = n;
      wpr_d = n <= 4'd4 ? 2'd1 : n <= 4'd8 ? 2'd2 : 2'd3;
      row_d = '0;
      blk_d = '0;
      addr_d = '0;
      last_d = 1'b0;
      state_d = m != 4'd0 && n != 4'd0 ? RUN : DONE;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      n_q <= '0;
      wpr_q <= '0;
      row_q <= '0;
      blk_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      n_q <= n_d;
      wpr_q <= wpr_d;
      row_q <= row_d;
      blk_q <= blk_d;
      addr_q <= addr_d;
      last_q <= last_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_gbuff_out_writer.sv
// tb_gbuff_out_writer: model-checked directed scenarios for the output writer
module tb_gbuff_out_writer;
  logic clk = 0, rst = 1, start = 0, res_valid = 0;
  logic [3:0] m = 0, n = 0;
  logic [31:0] res_data = 0;
  logic res_ready, wr_en, done;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  int n_chk = 0, n_fail = 0;
  logic [7:0] wa[$];
  logic [31:0] wd[$];

  gbuff_out_writer dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int words(input int cols);
    return cols <= 4 ? 1 : cols <= 8 ? 2 : 3;
  endfunction

  // behavioural model: job phase, beats accepted, and the write owed next cycle
  initial begin
    int ms, ms0, tot, acc, nn, blk;
    logic pend, fin_w;
    logic [7:0] pa;
    logic [31:0] pd;
    ms = 0; tot = 0; acc = 0; nn = 0; pend = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      chk("res_ready", 32'(res_ready), 32'(!rst && ms == 1 && acc < tot));
      chk("wr_en", 32'(wr_en), 32'(!rst && pend));
      chk("done", 32'(done), 32'(!rst && ms == 2));
      if (rst) begin
        chk("wr_addr_rst", 32'(wr_addr), 0);
        chk("wr_data_rst", wr_data, 0);
      end else if (pend) begin
        chk("wr_addr", 32'(wr_addr), 32'(pa));
        chk("wr_data", wr_data, pd);
      end
      if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
      end
      if (rst) begin
        ms = 0; acc = 0; tot = 0; pend = 0;
      end else begin
        ms0 = ms;
        fin_w = pend && ms == 1 && acc == tot;
        pend = res_valid && ms == 1 && acc < tot;
        if (pend) begin
          blk = acc % words(nn);
          pa = 8'(acc);
          pd = res_data;
          for (int j = 0; j < 4; j++) if (4 * blk + j >= nn) pd[8*j+:8] = 8'h00;
          acc++;
        end
        if (fin_w) ms = 2;
        if (ms0 != 1 && start) begin
          nn = int'(n);
          acc = 0;
          tot = int'(m) * words(int'(n));
          ms = (m != 0 && n != 0) ? 1 : 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] mm, input logic [3:0] nv);
    m = mm; n = nv; start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [31:0] beat);
    int w;
    w = 0;
    res_valid = 1;
    res_data = beat;
    while (!res_ready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk("send_timeout", 0, 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_ready", 32'(res_ready), 0);
    chk("reset_done", 32'(done), 0);
    rst = 0;
    tick();
    // scenario 1: m=2 n=4 back-to-back
    wa.delete(); wd.delete();
    do_start(2, 4);
    send(32'h04030201);
    send(32'h08070605);
    res_valid = 0;
    chk("s1_done_early", 32'(done), 0);
    tick();
    chk("s1_done", 32'(done), 1);
    chk("s1_count", 32'(wa.size()), 2);
    chk("s1_a1", 32'(wa[1]), 1);
    chk("s1_d0", wd[0], 32'h04030201);
    chk("s1_d1", wd[1], 32'h08070605);
    // scenario 2: m=1 n=6 lane masking
    wa.delete(); wd.delete();
    do_start(1, 6);
    send(32'hAABBCCDD);
    send(32'h11223344);
    res_valid = 0;
    tick(); tick();
    chk("s2_d0", wd[0], 32'hAABBCCDD);
    chk("s2_a1", 32'(wa[1]), 1);
    chk("s2_d1", wd[1], 32'h00003344);
    // scenario 3: m=3 n=12 with bubbles, and a start during RUN
    wa.delete(); wd.delete();
    do_start(3, 12);
    for (int k = 0; k < 9; k++) begin
      send(32'h01010101 * (k + 1));
      res_valid = 0;
      if (k == 3) begin
        m = 0; start = 1;
      end
      tick();
      start = 0;
    end
    tick(); tick();
    chk("s3_count", 32'(wa.size()), 9);
    chk("s3_a8", 32'(wa[8]), 8);
    chk("s3_d8", wd[8], 32'h09090909);
    chk("s3_done", 32'(done), 1);
    // scenario 4: empty job then a 1x1 job
    wa.delete(); wd.delete();
    do_start(0, 5);
    chk("s4_done", 32'(done), 1);
    repeat (3) tick();
    chk("s4_nowrite", 32'(wa.size()), 0);
    do_start(1, 1);
    chk("s4_done_clr", 32'(done), 0);
    send(32'hFFFFFFFF);
    res_valid = 0;
    tick(); tick();
    chk("s4_count", 32'(wa.size()), 1);
    chk("s4_a0", 32'(wa[0]), 0);
    chk("s4_d0", wd[0], 32'h000000FF);
    // scenario 5: reset mid-job, then a full restart
    wa.delete(); wd.delete();
    do_start(2, 8);
    send(32'h10203040);
    send(32'h50607080);
    res_valid = 0;
    tick();
    rst = 1; res_valid = 1; res_data = 32'hDEADBEEF;
    tick();
    rst = 0; res_valid = 0;
    chk("s5_count", 32'(wa.size()), 2);
    chk("s5_done", 32'(done), 0);
    chk("s5_ready", 32'(res_ready), 0);
    tick();
    wa.delete(); wd.delete();
    do_start(2, 8);
    for (int k = 0; k < 4; k++) send(32'hA0A0A0A0 + k);
    res_valid = 0;
    tick(); tick();
    chk("s5_restart_count", 32'(wa.size()), 4);
    chk("s5_a0", 32'(wa[0]), 0);
    chk("s5_a3", 32'(wa[3]), 3);
    // scenario 6: res_valid held high past the last beat
    wa.delete(); wd.delete();
    do_start(2, 3);
    send(32'h44332211);
    send(32'h88776655);
    chk("s6_ready_off", 32'(res_ready), 0);
    for (int k = 0; k < 5; k++) begin
      res_data = 32'hC0FFEE00 + k;
      tick();
    end
    res_valid = 0;
    chk("s6_count", 32'(wa.size()), 2);
    chk("s6_d0", wd[0], 32'h00332211);
    chk("s6_d1", wd[1], 32'h00776655);
    chk("s6_done", 32'(done), 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
